// File: rtl/cpu_pkg.sv
// Shared control-word bit map, status flag indices and multiplier FSM states,
// common to the control unit and the execution stage.
package cpu_pkg;

   localparam int unsigned CS_MBR2BR    = 6;
   localparam int unsigned CS_ACC2ALU   = 7;
   localparam int unsigned CS_MBR2ACC   = 10;
   localparam int unsigned CS_ACC2MBR   = 11;
   localparam int unsigned CS_BR2ALU    = 14;
   localparam int unsigned CS_MR2MBR    = 15;
   localparam int unsigned CS_ALU2MBR   = 16;
   localparam int unsigned CS_ACC_CLEAR = 21;
   localparam int unsigned CS_ADD       = 22;
   localparam int unsigned CS_SUB       = 23;
   localparam int unsigned CS_AND       = 24;
   localparam int unsigned CS_OR        = 25;
   localparam int unsigned CS_NOT       = 26;
   localparam int unsigned CS_LSL       = 27;
   localparam int unsigned CS_LSR       = 28;
   localparam int unsigned CS_MPY       = 29;
   localparam int unsigned CS_ASL       = 30;
   localparam int unsigned CS_ASR       = 31;

   localparam logic [31:0] CS_OP_MASK = 32'hFFC0_0000;

   localparam int unsigned FL_SIGN  = 0;
   localparam int unsigned FL_ZERO  = 1;
   localparam int unsigned FL_CARRY = 2;
   localparam int unsigned FL_OVF   = 3;
   localparam int unsigned FL_ILL   = 4;

   typedef enum logic [1:0] {
      MUL_IDLE,
      MUL_RUN,
      MUL_FIX
   } mul_state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier on operand magnitudes; one partial-product step
// per cycle, sign applied to the result in the FIX state.
module seq_mul
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [2*DATA_W-1:0]   product_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W);

   mul_state_e              state_q, state_d;
   logic [2*DATA_W-1:0]     mcand_q, mcand_d;
   logic [DATA_W:0]         mplier_q, mplier_d;
   logic [2*DATA_W-1:0]     prod_q, prod_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    neg_q, neg_d;

   // One extra bit so the most-negative operand has a representable magnitude.
   logic [DATA_W:0]         a_ext, b_ext, mag_a, mag_b;

   always_comb begin
      a_ext = {a_i[DATA_W-1], a_i};
      b_ext = {b_i[DATA_W-1], b_i};
      mag_a = a_ext[DATA_W] ? -a_ext : a_ext;
      mag_b = b_ext[DATA_W] ? -b_ext : b_ext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= MUL_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      unique case (state_q)
         MUL_IDLE: begin
            if (start_i) begin
               mcand_d  = {{(DATA_W-1){1'b0}}, mag_a};
               mplier_d = mag_b;
               prod_d   = '0;
               cnt_d    = '0;
               neg_d    = a_i[DATA_W-1] ^ b_i[DATA_W-1];
               state_d  = MUL_RUN;
            end
         end
         MUL_RUN: begin
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1)) state_d = MUL_FIX;
         end
         MUL_FIX: state_d = MUL_IDLE;
         default: state_d = MUL_IDLE;
      endcase
      if (abort_i) state_d = MUL_IDLE;
   end

   assign busy_o    = (state_q != MUL_IDLE);
   assign done_o    = (state_q == MUL_FIX);
   assign product_o = neg_q ? -prod_q : prod_q;

endmodule

// File: rtl/alu_acc.sv
// Execution stage: ACC/BR/MR registers, single-cycle ALU ops driven by the
// one-hot control word, and status flags returned to the control unit.
module alu_acc
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FLAG_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       control_signal,
   input  logic [DATA_W-1:0] mbr_in,
   output logic [DATA_W-1:0] data_to_mbr,
   output logic              mbr_wr,
   output logic [DATA_W-1:0] acc_out,
   output logic [FLAG_W-1:0] flags,
   output logic              busy
);

   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]   br_q, br_d;
   logic [DATA_W-1:0]   mr_q, mr_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;

   logic [31:0]         op_bits, op_one;
   logic                op_live, op_multi;
   logic [DATA_W:0]     sum, diff;
   logic                mul_start, mul_busy, mul_done;
   logic [2*DATA_W-1:0] mul_prod;

   seq_mul #(.DATA_W(DATA_W)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .abort_i   (control_signal[CS_ACC_CLEAR]),
      .a_i       (acc_q),
      .b_i       (br_q),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // Isolate the lowest-index op bit; extra op bits only raise the illegal flag.
   always_comb begin
      op_bits  = control_signal & CS_OP_MASK;
      op_one   = op_bits & (~op_bits + 32'd1);
      op_multi = (op_bits & (op_bits - 32'd1)) != '0;
      op_live  = !mul_busy && (op_bits != '0);
      sum      = {1'b0, acc_q} + {1'b0, br_q};
      diff     = {1'b0, acc_q} - {1'b0, br_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         br_q    <= '0;
         mr_q    <= '0;
         flags_q <= FLAG_W'(2);
      end else begin
         acc_q   <= acc_d;
         br_q    <= br_d;
         mr_q    <= mr_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      acc_d     = acc_q;
      br_d      = br_q;
      mr_d      = mr_q;
      flags_d   = flags_q;
      mul_start = 1'b0;
      if (control_signal[CS_MBR2BR])  br_d  = mbr_in;
      if (control_signal[CS_MBR2ACC]) acc_d = mbr_in;
      if (op_live) begin
         flags_d[FL_ILL] = op_multi;
         if (op_one[CS_ADD]) begin
            acc_d             = sum[DATA_W-1:0];
            flags_d[FL_CARRY] = sum[DATA_W];
            flags_d[FL_OVF]   = (acc_q[DATA_W-1] == br_q[DATA_W-1]) &&
                                (sum[DATA_W-1] != acc_q[DATA_W-1]);
         end else if (op_one[CS_SUB]) begin
            acc_d             = diff[DATA_W-1:0];
            flags_d[FL_CARRY] = ~diff[DATA_W];
            flags_d[FL_OVF]   = (acc_q[DATA_W-1] != br_q[DATA_W-1]) &&
                                (diff[DATA_W-1] != acc_q[DATA_W-1]);
         end else if (op_one[CS_AND] || op_one[CS_OR] || op_one[CS_NOT]) begin
            acc_d             = op_one[CS_AND] ? (acc_q & br_q) :
                                op_one[CS_OR]  ? (acc_q | br_q) : ~br_q;
            flags_d[FL_CARRY] = 1'b0;
            flags_d[FL_OVF]   = 1'b0;
         end else if (op_one[CS_LSL]) begin
            acc_d             = acc_q << 1;
            flags_d[FL_CARRY] = acc_q[DATA_W-1];
         end else if (op_one[CS_LSR]) begin
            acc_d             = acc_q >> 1;
            flags_d[FL_CARRY] = acc_q[0];
         end else if (op_one[CS_MPY]) begin
            mul_start = 1'b1;
         end else if (op_one[CS_ASL]) begin
            acc_d             = acc_q << 1;
            flags_d[FL_CARRY] = acc_q[DATA_W-1];
            flags_d[FL_OVF]   = acc_q[DATA_W-1] ^ acc_q[DATA_W-2];
         end else begin
            acc_d             = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
            flags_d[FL_CARRY] = acc_q[0];
         end
      end
      if (mul_done && !control_signal[CS_ACC_CLEAR]) begin
         {mr_d, acc_d}     = mul_prod;
         flags_d[FL_CARRY] = 1'b0;
         flags_d[FL_OVF]   = 1'b0;
         flags_d[FL_SIGN]  = mul_prod[2*DATA_W-1];
         flags_d[FL_ZERO]  = (mul_prod == '0);
      end else begin
         if (control_signal[CS_ACC_CLEAR]) acc_d = '0;
         flags_d[FL_SIGN] = acc_d[DATA_W-1];
         flags_d[FL_ZERO] = (acc_d == '0);
      end
   end

   always_comb begin
      data_to_mbr = '0;
      if (control_signal[CS_ACC2MBR])
         data_to_mbr = acc_q;
      else if (control_signal[CS_MR2MBR] || control_signal[CS_ALU2MBR])
         data_to_mbr = mr_q;
   end

   assign mbr_wr  = control_signal[CS_ACC2MBR] | control_signal[CS_MR2MBR] |
                    control_signal[CS_ALU2MBR];
   assign acc_out = acc_q;
   assign flags   = flags_q;
   assign busy    = mul_busy;

endmodule

// File: tb/tb_alu_acc.sv
// Directed bench for alu_acc: stimulus pushes hand-computed expectations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_alu_acc;
   import cpu_pkg::*;

   localparam int unsigned F_ACC = 0, F_FLAGS = 1, F_BUSY = 2, F_DMBR = 3, F_WR = 4;

   typedef struct {
      int unsigned cyc;
      int unsigned fld;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] control_signal;
   logic [15:0] mbr_in;
   logic [15:0] data_to_mbr;
   logic        mbr_wr;
   logic [15:0] acc_out;
   logic [7:0]  flags;
   logic        busy;

   exp_t        sb[$];
   int unsigned edge_cnt = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   alu_acc #(.DATA_W(16), .FLAG_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .control_signal (control_signal),
      .mbr_in         (mbr_in),
      .data_to_mbr    (data_to_mbr),
      .mbr_wr         (mbr_wr),
      .acc_out        (acc_out),
      .flags          (flags),
      .busy           (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   function automatic logic [31:0] bt(input int unsigned i);
      return 32'd1 << i;
   endfunction

   task automatic chk(input int unsigned fld, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc = edge_cnt; e.fld = fld; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   task automatic apply(input logic [31:0] cw, input logic [15:0] mbr);
      @(negedge clk); #1;
      control_signal = cw;
      mbr_in         = mbr;
      @(posedge clk); #1;
   endtask

   // Monitor: compare every expectation whose cycle has been reached.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
         exp_t        e;
         logic [31:0] act;
         e   = sb.pop_front();
         act = '0;
         case (e.fld)
            F_ACC:   act = 32'(acc_out);
            F_FLAGS: act = 32'(flags);
            F_BUSY:  act = 32'(busy);
            F_DMBR:  act = 32'(data_to_mbr);
            default: act = 32'(mbr_wr);
         endcase
         n_checks++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic run_mpy(input logic [15:0] acc_exp, input logic [7:0] fl_exp);
      apply(bt(CS_MPY), 16'h0);
      chk(F_BUSY, 1, "mpy_busy_start");
      for (int k = 1; k <= 17; k++) begin
         apply((k == 5) ? bt(CS_ADD) : 32'h0, 16'h0);
         if (k < 17) chk(F_BUSY, 1, "mpy_busy_run");
         if (k == 5) chk(F_FLAGS, 32'(fl_exp), "mpy_add_ignored_flags");
      end
      chk(F_BUSY, 0, "mpy_busy_end");
      chk(F_ACC, 32'(acc_exp), "mpy_acc");
   endtask

   initial begin
      rst = 1'b0; control_signal = '0; mbr_in = '0;
      #1;
      chk(F_ACC, 0, "rst_acc"); chk(F_FLAGS, 32'h02, "rst_flags");
      chk(F_BUSY, 0, "rst_busy"); chk(F_DMBR, 0, "rst_dmbr"); chk(F_WR, 0, "rst_wr");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      apply(bt(CS_MBR2BR) | bt(CS_ACC_CLEAR), 16'h0005);
      chk(F_ACC, 0, "load_clear_acc");
      apply(bt(CS_ADD), 16'h0);
      chk(F_ACC, 32'h0005, "add1_acc"); chk(F_FLAGS, 32'h00, "add1_flags");
      apply(bt(CS_MBR2BR), 16'hFFF9);
      apply(bt(CS_ADD), 16'h0);
      chk(F_ACC, 32'hFFFE, "add2_acc"); chk(F_FLAGS, 32'h01, "add2_flags");

      apply(bt(CS_MBR2ACC), 16'h8000);
      apply(bt(CS_MBR2BR), 16'h0001);
      apply(bt(CS_SUB), 16'h0);
      chk(F_ACC, 32'h7FFF, "sub_acc"); chk(F_FLAGS, 32'h0C, "sub_flags");

      apply(bt(CS_MBR2ACC), 16'h8001);
      apply(bt(CS_ASR), 16'h0);
      chk(F_ACC, 32'hC000, "asr_acc"); chk(F_FLAGS, 32'h0D, "asr_flags");
      apply(bt(CS_LSL), 16'h0);
      chk(F_ACC, 32'h8000, "lsl_acc"); chk(F_FLAGS, 32'h0D, "lsl_flags");
      apply(bt(CS_ASL), 16'h0);
      chk(F_ACC, 0, "asl_acc"); chk(F_FLAGS, 32'h0E, "asl_flags");

      apply(bt(CS_MBR2ACC), 16'h00F3);
      apply(bt(CS_LSR), 16'h0);
      chk(F_ACC, 32'h0079, "lsr_acc"); chk(F_FLAGS, 32'h0C, "lsr_flags");
      apply(bt(CS_AND), 16'h0);
      chk(F_ACC, 32'h0001, "and_acc"); chk(F_FLAGS, 32'h00, "and_flags");
      apply(bt(CS_NOT), 16'h0);
      chk(F_ACC, 32'hFFFE, "not_acc"); chk(F_FLAGS, 32'h01, "not_flags");

      apply(bt(CS_ADD) | bt(CS_SUB), 16'h0);
      chk(F_ACC, 32'hFFFF, "illegal_acc"); chk(F_FLAGS, 32'h11, "illegal_flags");
      apply(bt(CS_MBR2BR), 16'h0007);
      chk(F_FLAGS, 32'h11, "illegal_sticky");

      apply(bt(CS_MBR2ACC), 16'hFFFD);
      run_mpy(16'hFFEB, 8'h01);
      chk(F_FLAGS, 32'h01, "mpy_flags");
      apply(bt(CS_ALU2MBR), 16'h0);
      chk(F_DMBR, 32'hFFFF, "mpy_mr"); chk(F_WR, 1, "mpy_wr");
      apply(bt(CS_ACC2MBR) | bt(CS_ALU2MBR), 16'h0);
      chk(F_DMBR, 32'hFFEB, "dmbr_acc_priority");
      apply(32'h0, 16'h0);
      chk(F_WR, 0, "wr_idle"); chk(F_DMBR, 0, "dmbr_idle");

      apply(bt(CS_MBR2ACC), 16'h0005);
      apply(bt(CS_MPY), 16'h0);
      for (int k = 1; k <= 3; k++) apply(32'h0, 16'h0);
      apply(bt(CS_ACC_CLEAR), 16'h0);
      chk(F_BUSY, 0, "abort_busy"); chk(F_ACC, 0, "abort_acc"); chk(F_FLAGS, 32'h02, "abort_flags");
      apply(bt(CS_MR2MBR), 16'h0);
      chk(F_DMBR, 32'hFFFF, "abort_mr_kept"); chk(F_BUSY, 0, "abort_stays_idle");

      apply(bt(CS_MBR2BR) | bt(CS_MBR2ACC), 16'h8000);
      run_mpy(16'h0000, 8'h01);
      chk(F_FLAGS, 32'h00, "mpy_minneg_flags");
      apply(bt(CS_MR2MBR), 16'h0);
      chk(F_DMBR, 32'h4000, "mpy_minneg_mr");

      apply(bt(CS_MBR2ACC), 16'h0003);
      apply(bt(CS_MPY), 16'h0);
      for (int k = 1; k <= 3; k++) apply(32'h0, 16'h0);
      apply(bt(CS_MR2MBR), 16'h0);
      rst = 1'b0;
      #1;
      chk(F_ACC, 0, "midrst_acc"); chk(F_FLAGS, 32'h02, "midrst_flags");
      chk(F_BUSY, 0, "midrst_busy"); chk(F_DMBR, 0, "midrst_mr");
      @(posedge clk); #1 rst = 1'b1;
      apply(32'h0, 16'h0);
      apply(32'h0, 16'h0);
      chk(F_BUSY, 0, "postrst_busy"); chk(F_ACC, 0, "postrst_acc");

      apply(32'h0, 16'h0);
      apply(32'h0, 16'h0);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
